// File: rtl/mem_stage_pkg.sv
// Shared FSM state type and control-word bit positions for the memory stage.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FAULT = 2'd2
  } state_e;

  localparam int RD  = 3;
  localparam int WR  = 4;
  localparam int JMP = 6;
  localparam int BR  = 7;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Memory-side bus between the memory stage (master) and the data memory/cache (slave).
interface mem_stage_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);

  // Handshake: mreq is a one-cycle launch strobe; maddr/mwdata/mwr stay valid until the
  // access ends. The slave answers with exactly one mack cycle, no earlier than the cycle
  // after mreq; mhit, merr and mrdata are only meaningful while mack is high.
  logic              mreq;
  logic              mwr;
  logic              mdump;
  logic [ADDR_W-1:0] maddr;
  logic [DATA_W-1:0] mwdata;
  logic              mack;
  logic              mhit;
  logic              merr;
  logic [DATA_W-1:0] mrdata;

  modport master (
    output mreq, mwr, mdump, maddr, mwdata,
    input  mack, mhit, merr, mrdata
  );

  modport slave (
    input  mreq, mwr, mdump, maddr, mwdata,
    output mack, mhit, merr, mrdata
  );

endinterface

// File: rtl/mem_timeout_ctr.sv
// Counts WAIT cycles; expired_o flags the edge on which the count reaches TIMEOUT-1.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CNT_W'(1);
  end

  // Asserted one edge early so the registered timeout pulse lands in the last WAIT cycle.
  assign expired_o = en_i && (cnt_q == CNT_W'(TIMEOUT - 2));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory pipeline stage controller: launches loads/stores, waits for ack, flags faults,
// timeouts and deferred memory-dump requests.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int ALIGN_LG2 = 1,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [15:0]       ctrl,
  input  logic [ADDR_W-1:0] aluRsltIn,
  input  logic [DATA_W-1:0] memIn,
  input  logic [ADDR_W-1:0] PCImm,
  input  logic [ADDR_W-1:0] PC2,
  input  logic              halt,
  mem_stage_ctrl_if.master  mem,
  output logic [DATA_W-1:0] memOut,
  output logic [ADDR_W-1:0] InPC,
  output logic              Stall,
  output logic              Done,
  output logic              CacheHit,
  output logic              alignErrorMem,
  output logic              timeoutErr,
  output state_e            state_dbg
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << ALIGN_LG2) - 1);

  state_e            state_q, state_d;
  logic              mreq_q, mreq_d, mwr_q, mwr_d, mdump_q, mdump_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [DATA_W-1:0] mwdata_q, mwdata_d, mem_out_q, mem_out_d;
  logic              hit_q, hit_d, done_q, done_d, align_q, align_d, tmo_q, tmo_d;
  logic              halt_q, pend_q, pend_d;

  logic rd, wr, misaligned, launch, fault, ack_ok, ctr_en, ctr_expired, halt_rise, dump_ok;
  logic unused_ctrl;

  assign unused_ctrl = ^{ctrl[15:8], ctrl[5], ctrl[2:0]};

  // Alignment only matters for instructions that actually touch memory.
  always_comb begin
    rd         = ctrl[RD];
    wr         = ctrl[WR];
    misaligned = |(aluRsltIn & ALIGN_MASK);
    launch     = (state_q == IDLE) && valid_in && (rd ^ wr) && !misaligned;
    fault      = (state_q == IDLE) && valid_in && (rd | wr) && (misaligned || (rd && wr));
    ack_ok     = (state_q == WAIT) && mem.mack && !tmo_q;
    ctr_en     = (state_q == WAIT) && !mem.mack;
    halt_rise  = halt && !halt_q;
    dump_ok    = (state_q == IDLE) && !launch;
  end

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (launch),
    .en_i     (ctr_en),
    .expired_o(ctr_expired)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (launch)     state_d = WAIT;
        else if (fault) state_d = FAULT;
      end
      WAIT:    if (tmo_q || ack_ok) state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    maddr_d   = launch ? aluRsltIn : maddr_q;
    mwdata_d  = launch ? memIn : mwdata_q;
    mwr_d     = launch ? wr : mwr_q;
    mreq_d    = launch;
    done_d    = ack_ok && !mem.merr;
    align_d   = fault || (ack_ok && mem.merr);
    tmo_d     = ctr_expired;
    mem_out_d = (ack_ok && !mem.merr && !mwr_q) ? mem.mrdata : mem_out_q;
    hit_d     = (ack_ok && !mem.merr) ? mem.mhit : hit_q;
    // A halt edge seen while busy is remembered and served on the first free IDLE cycle.
    mdump_d   = dump_ok && (halt_rise || pend_q);
    pend_d    = dump_ok ? 1'b0 : (pend_q || halt_rise);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      mreq_q    <= 1'b0;
      mwr_q     <= 1'b0;
      mdump_q   <= 1'b0;
      maddr_q   <= '0;
      mwdata_q  <= '0;
      mem_out_q <= '0;
      hit_q     <= 1'b0;
      done_q    <= 1'b0;
      align_q   <= 1'b0;
      tmo_q     <= 1'b0;
      halt_q    <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mreq_q    <= mreq_d;
      mwr_q     <= mwr_d;
      mdump_q   <= mdump_d;
      maddr_q   <= maddr_d;
      mwdata_q  <= mwdata_d;
      mem_out_q <= mem_out_d;
      hit_q     <= hit_d;
      done_q    <= done_d;
      align_q   <= align_d;
      tmo_q     <= tmo_d;
      halt_q    <= halt;
      pend_q    <= pend_d;
    end
  end

  assign mem.mreq      = mreq_q;
  assign mem.mwr       = mwr_q;
  assign mem.mdump     = mdump_q;
  assign mem.maddr     = maddr_q;
  assign mem.mwdata    = mwdata_q;
  assign memOut        = mem_out_q;
  assign CacheHit      = hit_q;
  assign Done          = done_q;
  assign alignErrorMem = align_q;
  assign timeoutErr    = tmo_q;
  assign state_dbg     = state_q;
  assign InPC          = (ctrl[JMP] | ctrl[BR]) ? PCImm : PC2;
  assign Stall         = launch || ((state_q == WAIT) && !ack_ok);

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, data width of load/store path.
REQ-002 Parameter ADDR_W, default 16, width of address and PC values.
REQ-003 Parameter ALIGN_LG2, default 1, log2 of required access alignment in bytes (0 disables the alignment check).
REQ-004 Parameter TIMEOUT, default 64, maximum WAIT cycles before a memory timeout error (must be >= 2).
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 valid_in  in  1  the current instruction in this stage is valid.
REQ-008 ctrl  in  16  control word; bit 3 memRead, bit 4 memWrite, bit 6 jump, bit 7 branch.
REQ-009 aluRsltIn  in  ADDR_W  effective address.
REQ-010 memIn  in  DATA_W  store data.
REQ-011 PCImm, PC2  in  ADDR_W  target PC and sequential PC.
REQ-012 halt  in  1  request a memory dump.
REQ-013 mreq, mwr, mdump  out  1  memory request strobe, write qualifier, dump strobe.
REQ-014 maddr  out  ADDR_W; mwdata  out  DATA_W  registered request address and data.
REQ-015 mack, mhit, merr  in  1  memory completion, cache hit and error, valid with mack.
REQ-016 mrdata  in  DATA_W  read data, valid with mack.
REQ-017 memOut  out  DATA_W; InPC  out  ADDR_W; Stall, Done, CacheHit, alignErrorMem, timeoutErr  out  1.

Function
REQ-018 InPC SHALL be combinational: PCImm if jump or branch, else PC2.
REQ-019 The FSM SHALL have states IDLE, WAIT, FAULT.
REQ-020 In IDLE with valid_in and exactly one of memRead/memWrite, and the low ALIGN_LG2 address bits zero: mreq=1 for one cycle; maddr, mwdata and mwr registered on that edge; next state WAIT.
REQ-021 In IDLE with valid_in and (misaligned address, or memRead and memWrite both set): no mreq; next state FAULT.
REQ-022 FAULT SHALL last one cycle with alignErrorMem=1; next state IDLE.
REQ-023 In WAIT, mack=1 SHALL return to IDLE, pulse Done for one cycle, register CacheHit from mhit and, for reads, register memOut from mrdata.
REQ-024 In WAIT, mack with merr=1 SHALL instead pulse alignErrorMem for one cycle, leave memOut unchanged and return to IDLE.
REQ-025 A WAIT cycle counter SHALL clear on entry to WAIT; if it reaches TIMEOUT-1 with no mack, timeoutErr pulses for one cycle and the FSM returns to IDLE.
REQ-026 Stall SHALL be combinational: 1 in IDLE when a legal access is being launched, and 1 in WAIT unless mack=1.
REQ-027 mack SHALL be ignored in IDLE and FAULT; earliest legal mack is the cycle after mreq.
REQ-028 memOut SHALL hold its last loaded value until the next successful read.
REQ-029 halt in IDLE with no access launching SHALL pulse mdump once per rising edge of halt; halt arriving during WAIT or FAULT SHALL be deferred and mdump pulsed on the first IDLE cycle.
REQ-030 Upstream SHALL hold valid_in, ctrl, aluRsltIn and memIn stable while Stall=1; the block does not re-sample them in WAIT.

Reset
REQ-031 rst low SHALL immediately force: state IDLE, counter 0, memOut 0, maddr 0, mwdata 0, mwr 0, CacheHit 0, halt-pending flag 0.
REQ-032 Registered pulses (mreq, Done, alignErrorMem, timeoutErr, mdump) SHALL be 0 during reset and in the first cycle after release.
REQ-033 Reset during WAIT SHALL abandon the access; a late mack after release SHALL be ignored.

Structure
REQ-034 A shared package mem_stage_pkg SHALL hold the state enum and ctrl bit-index constants (RD=3, WR=4, JMP=6, BR=7).
REQ-035 The WAIT timeout counter SHALL be a sub-module mem_timeout_ctr (clear, enable, expired), width $clog2(TIMEOUT).

Verification
REQ-036 Aligned read addr 0x0010, mack 3 cycles after mreq, mrdata 0xBEEF, mhit=1 -> Stall high 4 cycles, Done one pulse, memOut=0xBEEF, CacheHit=1.
REQ-037 Write to 0x0011 with ALIGN_LG2=1 -> no mreq, alignErrorMem one pulse, Stall 0, memOut unchanged.
REQ-038 Read, mack never asserted, TIMEOUT=8 -> timeoutErr pulses in 8th WAIT cycle, FSM IDLE next cycle.
REQ-039 halt during WAIT of a write -> mdump=0 until Done, then mdump one pulse on the next IDLE cycle.
REQ-040 rst low in WAIT cycle 2, mack pulsed after release -> no Done, memOut=0, mreq=0.
REQ-041 ctrl jump=1, PCImm=0x0040, PC2=0x0012 -> InPC=0x0040; jump=branch=0 -> InPC=0x0012.
